// File: rtl/emio_spi_pkg.sv
// Shared types and constants for the EMIO-driven SPI register responder.
// Frame layout, FSM states, EMIO status bit positions and register map.
package emio_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } spi_state_t;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;

    // Field positions within the 16-bit frame (MSB first on the wire)
    localparam int RW_POS   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 12;
    localparam int DATA_MSB = 7;

    // Status bits returned to the PS on EMIO
    localparam int MISO_BIT = 3;
    localparam int DONE_BIT = 4;
    localparam int BUSY_BIT = 5;

    localparam logic [2:0] REG_ID  = 3'd0;
    localparam logic [2:0] REG_ERR = 3'd7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/emio_sync.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synchronized value.
// Latency: 2 cycles to dout, edge pulses one cycle wide; no backpressure.
module emio_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [1:0] meta;
    logic       prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= {2{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            meta <= {meta[0], din};
            prev <= meta[1];
        end
    end

    assign dout = meta[1];
    assign rise = meta[1] & ~prev;
    assign fall = ~meta[1] & prev;

endmodule

// File: rtl/emio_spi_responder.sv
// SPI mode-0 register responder bit-banged by the PS over EMIO GPIO.
// Latency: ~3 fclk cycles from a PS line change to its effect; no backpressure, PS half-period >= 4 cycles.
module emio_spi_responder
    import emio_spi_pkg::*;
#(
    parameter int         SCLK_BIT = 0,
    parameter int         MOSI_BIT = 1,
    parameter int         CSN_BIT  = 2,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic        fclk_clk0,
    input  logic        peripheral_reset,
    input  logic [5:0]  emio_user_tri_o,
    input  logic [5:0]  emio_user_tri_t,
    output logic [5:0]  emio_user_tri_i,
    output logic [47:0] cfg_o,
    output logic [5:0]  cfg_wr_o
);

    // A line the PS is not driving reads as its idle level
    logic sclk_raw, mosi_raw, csn_raw;
    assign sclk_raw = emio_user_tri_t[SCLK_BIT] ? 1'b0 : emio_user_tri_o[SCLK_BIT];
    assign mosi_raw = emio_user_tri_t[MOSI_BIT] ? 1'b0 : emio_user_tri_o[MOSI_BIT];
    assign csn_raw  = emio_user_tri_t[CSN_BIT]  ? 1'b1 : emio_user_tri_o[CSN_BIT];

    logic sclk_s, sclk_rise, sclk_fall;
    logic csn_s, cs_rise, cs_fall;
    logic [1:0] mosi_meta;
    logic mosi_s;

    emio_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (fclk_clk0),
        .rst  (peripheral_reset),
        .din  (sclk_raw),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs_n is active low: its rising edge ends a frame
    emio_sync #(.RST_VAL(1'b1)) u_csn_sync (
        .clk  (fclk_clk0),
        .rst  (peripheral_reset),
        .din  (csn_raw),
        .dout (csn_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge fclk_clk0) begin
        if (peripheral_reset) begin
            mosi_meta <= 2'b00;
        end else begin
            mosi_meta <= {mosi_meta[0], mosi_raw};
        end
    end
    assign mosi_s = mosi_meta[1];

    spi_state_t  state, state_nxt;
    logic [4:0]  bit_cnt;
    logic [7:0]  sh_in, sh_nxt, sh_out;
    logic [7:0]  err_cnt, rd_val;
    logic [2:0]  addr_q, rd_addr;
    logic        rd_frame, miso_q, done_q, miso;
    logic [47:0] cfg_q;
    logic [5:0]  wr_stage;
    logic        bit_take, last_cmd, last_data;

    // cs_n rising wins over a coincident sclk edge
    assign bit_take  = sclk_rise & ~cs_rise & ((state == ST_CMD) | (state == ST_DATA));
    assign last_cmd  = bit_take & (bit_cnt == 5'(CMD_BITS - 1));
    assign last_data = bit_take & (bit_cnt == 5'(FRAME_BITS - 1));
    assign sh_nxt    = {sh_in[6:0], mosi_s};
    assign rd_addr   = sh_nxt[ADDR_MSB-CMD_BITS -: 3];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (cs_rise)       state_nxt = ST_IDLE;
                else if (last_cmd) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (cs_rise)        state_nxt = ST_IDLE;
                else if (last_data) state_nxt = ST_DONE;
            end
            ST_DONE: if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = ID_VALUE;
        case (rd_addr)
            REG_ID:  rd_val = ID_VALUE;
            REG_ERR: rd_val = err_cnt;
            default: rd_val = cfg_q[{rd_addr - 3'd1, 3'b000} +: 8];
        endcase
    end

    always_ff @(posedge fclk_clk0) begin
        if (peripheral_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge fclk_clk0) begin
        if (peripheral_reset) begin
            bit_cnt  <= '0;
            sh_in    <= '0;
            sh_out   <= '0;
            addr_q   <= '0;
            rd_frame <= 1'b0;
            miso_q   <= 1'b0;
            done_q   <= 1'b0;
            err_cnt  <= '0;
            cfg_q    <= '0;
            wr_stage <= '0;
            cfg_wr_o <= '0;
        end else begin
            wr_stage <= '0;
            cfg_wr_o <= wr_stage;
            if (cs_fall) begin
                bit_cnt  <= '0;
                done_q   <= 1'b0;
                miso_q   <= 1'b0;
                rd_frame <= 1'b0;
            end else if (cs_rise) begin
                if (bit_cnt != 5'd0 && bit_cnt < 5'(FRAME_BITS))
                    err_cnt <= sat_inc8(err_cnt);
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else if (bit_take) begin
                bit_cnt <= bit_cnt + 5'd1;
                sh_in   <= sh_nxt;
                if (last_cmd) begin
                    rd_frame <= sh_nxt[RW_POS-CMD_BITS];
                    addr_q   <= rd_addr;
                    sh_out   <= rd_val;
                end
                if (last_data) begin
                    done_q <= 1'b1;
                    if (!rd_frame && addr_q != REG_ID && addr_q != REG_ERR) begin
                        cfg_q[{addr_q - 3'd1, 3'b000} +: 8] <= sh_nxt[DATA_MSB:0];
                        wr_stage[addr_q - 3'd1]             <= 1'b1;
                    end
                end
            end else if (sclk_fall && state == ST_DATA && rd_frame) begin
                miso_q <= sh_out[7];
                sh_out <= {sh_out[6:0], 1'b0};
            end
        end
    end

    assign miso  = (state == ST_DATA && rd_frame) ? miso_q : 1'b0;
    assign cfg_o = cfg_q;

    always_comb begin
        emio_user_tri_i           = '0;
        emio_user_tri_i[MISO_BIT] = miso;
        emio_user_tri_i[DONE_BIT] = done_q;
        emio_user_tri_i[BUSY_BIT] = (state != ST_IDLE);
        emio_user_tri_i[SCLK_BIT] = emio_user_tri_o[SCLK_BIT];
        emio_user_tri_i[MOSI_BIT] = emio_user_tri_o[MOSI_BIT];
        emio_user_tri_i[CSN_BIT]  = emio_user_tri_o[CSN_BIT];
    end

    // Status-bit positions of tri_o/tri_t and the synchronized sclk level carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{emio_user_tri_o, emio_user_tri_t, sclk_s, csn_s};

endmodule

// File: tb/tb_emio_spi_responder.sv
// Directed table-driven bench for emio_spi_responder, PS side bit-banged over EMIO.
module tb_emio_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  tri_o;
    logic [5:0]  tri_t;
    logic [5:0]  tri_i;
    logic [47:0] cfg;
    logic [5:0]  cfg_wr;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_pulses = 0;
    logic [5:0] wr_seen = '0;

    always #5 clk = ~clk;

    emio_spi_responder dut (
        .fclk_clk0        (clk),
        .peripheral_reset (rst),
        .emio_user_tri_o  (tri_o),
        .emio_user_tri_t  (tri_t),
        .emio_user_tri_i  (tri_i),
        .cfg_o            (cfg),
        .cfg_wr_o         (cfg_wr)
    );

    always @(negedge clk) begin
        if (cfg_wr != 6'd0) begin
            wr_pulses = wr_pulses + 1;
            wr_seen   = wr_seen | cfg_wr;
        end
    end

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic [7:0]  exp_miso;
        logic [47:0] exp_cfg;
        logic [5:0]  exp_wr;
        bit          chk_done;
        logic        exp_done;
    } vec_t;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_xfer(input logic [15:0] word, input int nbits, input bit raise_cs,
                            output logic [7:0] rx);
        rx = 8'h00;
        wr_pulses = 0;
        wr_seen = '0;
        tri_o[2] = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            tri_o[1] = (i < 16) ? word[15 - i] : 1'b1;
            wait_cyc(HALF);
            if (i >= 8 && i < 16) rx = {rx[6:0], tri_i[3]};
            tri_o[0] = 1'b1;
            wait_cyc(HALF);
            tri_o[0] = 1'b0;
        end
        wait_cyc(HALF);
        if (raise_cs) begin
            tri_o[1] = 1'b0;
            tri_o[2] = 1'b1;
            wait_cyc(8);
        end
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [7:0] rx);
        spi_xfer({1'b1, addr, 12'h000}, 16, 1'b1, rx);
    endtask

    vec_t       vecs[12];
    logic [7:0] rx;
    logic [47:0] cfg_keep;

    initial begin
        vecs[0]  = '{16'h203C, 16, 8'h00, 48'h0000_0000_3C00, 6'b000010, 1'b1, 1'b1};
        vecs[1]  = '{16'h8000, 16, 8'hA5, 48'h0000_0000_3C00, 6'b000000, 1'b1, 1'b1};
        vecs[2]  = '{16'h1055, 11, 8'h00, 48'h0000_0000_3C00, 6'b000000, 1'b1, 1'b0};
        vecs[3]  = '{16'hF000, 16, 8'h01, 48'h0000_0000_3C00, 6'b000000, 1'b1, 1'b1};
        vecs[4]  = '{16'hA000, 16, 8'h3C, 48'h0000_0000_3C00, 6'b000000, 1'b1, 1'b1};
        vecs[5]  = '{16'h6081, 16, 8'h00, 48'h8100_0000_3C00, 6'b100000, 1'b1, 1'b1};
        vecs[6]  = '{16'h00FF, 16, 8'h00, 48'h8100_0000_3C00, 6'b000000, 1'b0, 1'b0};
        vecs[7]  = '{16'h7012, 16, 8'h00, 48'h8100_0000_3C00, 6'b000000, 1'b0, 1'b0};
        vecs[8]  = '{16'hF000, 16, 8'h01, 48'h8100_0000_3C00, 6'b000000, 1'b1, 1'b1};
        vecs[9]  = '{16'hE000, 16, 8'h81, 48'h8100_0000_3C00, 6'b000000, 1'b1, 1'b1};
        vecs[10] = '{16'h3F44, 16, 8'h00, 48'h8100_0044_3C00, 6'b000100, 1'b1, 1'b1};
        vecs[11] = '{16'hBAAA, 16, 8'h44, 48'h8100_0044_3C00, 6'b000000, 1'b1, 1'b1};

        rst   = 1'b1;
        tri_o = 6'b000100;
        tri_t = 6'b111000;
        wait_cyc(5);
        chk("reset_cfg", cfg, 48'h0);
        chk("reset_cfg_wr", {42'h0, cfg_wr}, 48'h0);
        chk("reset_tri_i", {42'h0, tri_i}, {42'h0, 6'b000100});
        rst = 1'b0;
        wait_cyc(5);
        chk("idle_tri_i", {42'h0, tri_i}, {42'h0, 6'b000100});

        for (int v = 0; v < 12; v++) begin
            spi_xfer(vecs[v].word, vecs[v].nbits, 1'b1, rx);
            chk($sformatf("v%0d_cfg", v), cfg, vecs[v].exp_cfg);
            chk($sformatf("v%0d_wr_mask", v), {42'h0, wr_seen}, {42'h0, vecs[v].exp_wr});
            chk($sformatf("v%0d_wr_cycles", v), 48'(wr_pulses), (vecs[v].exp_wr != 6'd0) ? 48'd1 : 48'd0);
            if (vecs[v].chk_done)
                chk($sformatf("v%0d_done", v), {47'h0, tri_i[4]}, {47'h0, vecs[v].exp_done});
            if (vecs[v].word[15])
                chk($sformatf("v%0d_miso", v), {40'h0, rx}, {40'h0, vecs[v].exp_miso});
            chk($sformatf("v%0d_busy", v), {47'h0, tri_i[5]}, 48'h0);
        end

        // Edges past the 16th are ignored: write addr 4, two extra clocks
        spi_xfer(16'h40C3, 18, 1'b1, rx);
        chk("long_cfg", cfg, 48'h8100_C344_3C00);
        chk("long_wr_mask", {42'h0, wr_seen}, {42'h0, 6'b001000});
        read_reg(3'd7, rx);
        chk("long_err", {40'h0, rx}, 48'h01);

        // sclk not driven by the PS: toggles must not be seen
        cfg_keep = cfg;
        tri_t[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tri_o[0] = ~tri_o[0];
            wait_cyc(HALF);
            if (i == 2) chk("tri_loopback_sclk", {47'h0, tri_i[0]}, {47'h0, tri_o[0]});
        end
        chk("trit_idle_busy", {47'h0, tri_i[5]}, 48'h0);
        tri_o[0] = 1'b0;
        spi_xfer(16'h10FF, 16, 1'b1, rx);
        chk("trit_cfg", cfg, cfg_keep);
        chk("trit_wr", 48'(wr_pulses), 48'd0);
        tri_t[0] = 1'b0;
        read_reg(3'd7, rx);
        chk("trit_err", {40'h0, rx}, 48'h01);

        // Error counter saturation
        for (int i = 0; i < 300; i++) spi_xfer(16'h8000, 1, 1'b1, rx);
        read_reg(3'd7, rx);
        chk("err_sat", {40'h0, rx}, 48'hFF);
        chk("err_sat_cfg", cfg, cfg_keep);

        // Reset in the middle of a write frame
        spi_xfer(16'h1077, 12, 1'b0, rx);
        chk("mid_busy", {47'h0, tri_i[5]}, 48'h1);
        rst = 1'b1;
        tri_o = 6'b000100;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(5);
        chk("rst_cfg", cfg, 48'h0);
        chk("rst_busy", {47'h0, tri_i[5]}, 48'h0);
        read_reg(3'd7, rx);
        chk("rst_err", {40'h0, rx}, 48'h00);
        spi_xfer(16'h6081, 16, 1'b1, rx);
        chk("post_rst_cfg", cfg, 48'h8100_0000_0000);
        chk("post_rst_wr", {42'h0, wr_seen}, {42'h0, 6'b100000});
        chk("post_rst_wr_cycles", 48'(wr_pulses), 48'd1);
        chk("post_rst_done", {47'h0, tri_i[4]}, 48'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
